// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - streams a configuration bitstream into a ccff chain and reads the old contents back
//
// Ports:
//   prog_clk, pReset               configuration clock, asynchronous active-low reset
//   start, abort                   begin a load (sampled in IDLE), cancel any load
//   cfg_data/cfg_valid/cfg_ready   bitstream words in, MSB shifted first
//   ccff_head, ccff_shift_en       serial bit into the chain head, chain shift enable
//   ccff_tail                      serial bit out of the chain tail (old contents)
//   rb_data/rb_valid/rb_ready      captured readback words out, right-justified
//   busy, done                     not IDLE, one-cycle completion pulse
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 58,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_RB_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    logic              rb_stall;
    logic              last_bit;
    logic              word_end;
    logic [WORD_W-1:0] cap_next;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        bit_idx_d     = bit_idx_q;
        word_d        = word_q;
        cap_d         = cap_q;
        rb_data_d     = rb_data_q;
        rb_valid_d    = rb_valid_q;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        done          = 1'b0;

        // A readback word still waiting for its consumer blocks both fetching
        // and shifting, so no captured bit can be overwritten.
        rb_stall = rb_valid_q && !rb_ready;
        last_bit = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
        word_end = (bit_idx_q == '0);
        // Capture register starts cleared per word, so shifting in at the LSB
        // leaves a short final word right-justified and zero-padded.
        cap_next = {cap_q[WORD_W-2:0], ccff_tail};

        if (rb_valid_q && rb_ready) begin
            rb_valid_d = 1'b0;
        end

        if (abort) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            bit_idx_d  = IDX_W'(WORD_W - 1);
            cap_d      = '0;
            rb_valid_d = 1'b0;
            rb_data_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_FETCH;
                        bit_cnt_d = '0;
                        cap_d     = '0;
                    end
                end
                S_FETCH: begin
                    cfg_ready = !rb_stall;
                    if (cfg_valid && !rb_stall) begin
                        word_d    = cfg_data;
                        bit_idx_d = IDX_W'(WORD_W - 1);
                        state_d   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!rb_stall) begin
                        ccff_shift_en = 1'b1;
                        ccff_head     = word_q[bit_idx_q];
                        bit_cnt_d     = bit_cnt_q + 1'b1;
                        bit_idx_d     = word_end ? bit_idx_q : bit_idx_q - 1'b1;
                        if (word_end || last_bit) begin
                            rb_data_d  = cap_next;
                            rb_valid_d = 1'b1;
                            cap_d      = '0;
                            state_d    = last_bit ? S_RB_WAIT : S_FETCH;
                        end else begin
                            cap_d = cap_next;
                        end
                    end
                end
                S_RB_WAIT: begin
                    if (!rb_valid_q || rb_ready) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= IDX_W'(WORD_W - 1);
            word_q     <= '0;
            cap_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            word_q     <= word_d;
            cap_q      <= cap_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader
module tb_ccff_chain_loader;

    localparam int CL = 58;
    localparam int WW = 32;

    logic          prog_clk  = 1'b0;
    logic          pReset    = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          rb_ready  = 1'b1;
    logic [WW-1:0] cfg_data;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic [WW-1:0] rb_data;
    logic          rb_valid;
    logic          busy;
    logic          done;

    int nchk = 0;
    int nerr = 0;

    logic [WW-1:0] words [4];
    logic [CL-1:0] chain;
    logic [CL-1:0] chain_init = '0;
    logic          tb_clr = 1'b0;
    int            wptr = 0;
    bit            head_q [$];
    logic [WW-1:0] rb_q [$];

    logic sh_a [200];
    logic cr_a [200];
    logic rv_a [200];
    logic dn_a [200];
    logic by_a [200];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .rb_ready      (rb_ready),
        .busy          (busy),
        .done          (done)
    );

    // Environment: word source, the physical chain, and a readback collector.
    assign cfg_data  = words[wptr[1:0]];
    assign ccff_tail = chain[CL-1];

    always @(posedge prog_clk) begin
        if (tb_clr) begin
            wptr  <= 0;
            chain <= chain_init;
            head_q.delete();
            rb_q.delete();
        end else begin
            if (cfg_valid && cfg_ready) wptr <= wptr + 1;
            if (ccff_shift_en) begin
                chain <= {chain[CL-2:0], ccff_head};
                head_q.push_back(ccff_head);
            end
            if (rb_valid && rb_ready) rb_q.push_back(rb_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the cycle in which start is presented.
    task automatic run_load(input int stall, input int abort_cyc, input int restart_cyc, input int ncyc);
        tb_clr = 1'b1;
        @(posedge prog_clk); #1;
        tb_clr    = 1'b0;
        cfg_valid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            start    = (c == 0) || (c == restart_cyc);
            abort    = (c == abort_cyc);
            rb_ready = !(c >= 34 && c < 34 + stall);
            @(negedge prog_clk);
            sh_a[c] = ccff_shift_en;
            cr_a[c] = cfg_ready;
            rv_a[c] = rb_valid;
            dn_a[c] = done;
            by_a[c] = busy;
            @(posedge prog_clk); #1;
        end
        start     = 1'b0;
        abort     = 1'b0;
        rb_ready  = 1'b1;
        cfg_valid = 1'b0;
    endtask

    // Expected cycle pattern for a 58-bit/32-bit load with the first readback
    // word held off for s cycles.
    task automatic check_timing(input string tag, input int s, input int n);
        int m_sh, m_cr, m_rv, m_dn, m_by;
        m_sh = 0; m_cr = 0; m_rv = 0; m_dn = 0; m_by = 0;
        for (int c = 0; c < n; c++) begin
            if (sh_a[c] !== ((c >= 2 && c <= 33) || (c >= 35 + s && c <= 60 + s))) m_sh++;
            if (cr_a[c] !== ((c == 1) || (c == 34 + s))) m_cr++;
            if (rv_a[c] !== ((c >= 34 && c <= 34 + s) || (c == 61 + s))) m_rv++;
            if (dn_a[c] !== (c == 62 + s)) m_dn++;
            if (by_a[c] !== (c >= 1 && c <= 62 + s)) m_by++;
        end
        chk({tag, "_shift_en_cycles"}, m_sh, 0);
        chk({tag, "_cfg_ready_cycles"}, m_cr, 0);
        chk({tag, "_rb_valid_cycles"}, m_rv, 0);
        chk({tag, "_done_cycles"}, m_dn, 0);
        chk({tag, "_busy_cycles"}, m_by, 0);
    endtask

    task automatic check_data(input string tag, input int nb);
        int            mism;
        int            nw;
        int            hi;
        bit            b;
        logic [WW-1:0] w;
        logic [CL-1:0] exp_chain;
        chk({tag, "_nbits"}, head_q.size(), nb);
        mism = 0;
        exp_chain = chain_init;
        for (int i = 0; i < nb; i++) begin
            b = words[i / WW][WW - 1 - (i % WW)];
            if (i < head_q.size() && head_q[i] !== b) mism++;
            exp_chain[CL - 1 - i] = b;
        end
        chk({tag, "_head_order"}, mism, 0);
        if (nb == CL) begin
            chk({tag, "_chain_contents"}, chain, exp_chain);
            nw = (CL + WW - 1) / WW;
            chk({tag, "_rb_count"}, rb_q.size(), nw);
            for (int k = 0; k < nw; k++) begin
                w  = '0;
                hi = (k + 1) * WW;
                if (hi > CL) hi = CL;
                for (int i = k * WW; i < hi; i++) w = {w[WW-2:0], chain_init[CL - 1 - i]};
                chk($sformatf("%s_rb_word%0d", tag, k), (k < rb_q.size()) ? rb_q[k] : 'x, w);
            end
        end
    endtask

    task automatic randomize_load();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        r = {$urandom, $urandom};
        chain_init = r[CL-1:0];
    endtask

    initial begin
        int dcount;

        // Reset state
        cfg_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        chk("reset_outputs", {cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, rb_data}, '0);
        pReset = 1'b1;

        // Directed load: known words, chain preloaded with ones
        words[0] = 32'hA5A5A5A5;
        words[1] = 32'hFFFFFFC0;
        words[2] = '0;
        words[3] = '0;
        chain_init = '1;
        run_load(0, -1, -1, 66);
        check_timing("basic", 0, 66);
        check_data("basic", CL);
        chk("basic_rb_word1_const", (rb_q.size() > 1) ? rb_q[1] : 'x, 32'h03FFFFFF);

        // Random load with readback back-pressure for 10 cycles
        randomize_load();
        run_load(10, -1, -1, 76);
        check_timing("stall", 10, 76);
        check_data("stall", CL);

        // Abort at bit 40
        randomize_load();
        run_load(0, 43, -1, 60);
        dcount = 0;
        for (int c = 0; c < 60; c++) if (dn_a[c] === 1'b1) dcount++;
        chk("abort_busy_next", by_a[44], 1'b0);
        chk("abort_rb_valid_next", rv_a[44], 1'b0);
        chk("abort_no_done", dcount, 0);
        check_data("abort", 40);

        // Reload after abort
        randomize_load();
        run_load(0, -1, -1, 66);
        check_timing("reload", 0, 66);
        check_data("reload", CL);

        // Reset in the middle of a shift
        randomize_load();
        tb_clr = 1'b1;
        @(posedge prog_clk); #1;
        tb_clr    = 1'b0;
        cfg_valid = 1'b1;
        start     = 1'b1;
        repeat (20) begin
            @(posedge prog_clk); #1;
            start = 1'b0;
        end
        chk("pre_reset_shift_en", ccff_shift_en, 1'b1);
        pReset = 1'b0;
        #1;
        chk("mid_reset_outputs", {cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, rb_data}, '0);
        @(posedge prog_clk); #1;
        pReset = 1'b1;
        repeat (5) @(posedge prog_clk);
        @(negedge prog_clk);
        chk("no_resume_after_reset", {busy, ccff_shift_en, cfg_ready}, '0);
        cfg_valid = 1'b0;

        // Start while busy is ignored
        randomize_load();
        run_load(0, -1, 10, 66);
        check_timing("start_busy", 0, 66);
        check_data("start_busy", CL);

        // Start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge prog_clk);
        chk("start_abort_idle_busy", busy, 1'b0);
        @(posedge prog_clk);
        @(negedge prog_clk);
        chk("start_abort_idle_busy_later", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
